// File: rtl/llc_lookup_ctrl_pkg.sv
// llc_lookup_ctrl_pkg
//   Shared cache constants and types for the LLC lookup controller and its
//   way selector: geometry (ways, sets), tag/state/way/set types, the line
//   state encodings, the controller FSM state type and a wrap-around way
//   increment helper.
package llc_lookup_ctrl_pkg;

  // Cache geometry
  localparam int LLC_WAYS     = 8;
  localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);
  localparam int LLC_SETS     = 16;
  localparam int LLC_SET_BITS = $clog2(LLC_SETS);
  localparam int LLC_TAG_BITS = 16;

  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [1:0]              llc_state_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;
  typedef logic [LLC_SET_BITS-1:0] llc_set_t;

  // Line state encodings
  localparam llc_state_t INVALID = 2'd0;
  localparam llc_state_t VALID   = 2'd1;
  localparam llc_state_t SD      = 2'd2;

  // Controller FSM states
  typedef logic [2:0] llc_lookup_state_t;
  localparam llc_lookup_state_t ST_IDLE   = 3'd0;
  localparam llc_lookup_state_t ST_READ   = 3'd1;
  localparam llc_lookup_state_t ST_WAIT   = 3'd2;
  localparam llc_lookup_state_t ST_LOOKUP = 3'd3;
  localparam llc_lookup_state_t ST_RESP   = 3'd4;

  // Way index w+k, wrapping modulo LLC_WAYS.
  function automatic llc_way_t way_add(input llc_way_t w, input int k);
    return llc_way_t'((int'(w) + k) % LLC_WAYS);
  endfunction

endpackage

// File: rtl/llc_lookup_ctrl_lookup_way.sv
// lookup_way
//   Way selector for one LLC set. On lookup_en it registers the chosen way and
//   whether that way must be evicted. Priority: tag hit on a live way, lowest
//   INVALID way, first VALID way from evict_ptr, first non-SD way from
//   evict_ptr, else evict_ptr itself.
//   Ports: clk, rst (async, active-low), lookup_en, tags/states (the set's
//   contents), tag (lookup tag), evict_ptr (round-robin start), way, evict.
module lookup_way
  import llc_lookup_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lookup_en,
  input  llc_tag_t   tags   [LLC_WAYS],
  input  llc_state_t states [LLC_WAYS],
  input  llc_tag_t   tag,
  input  llc_way_t   evict_ptr,
  output llc_way_t   way,
  output logic       evict
);

  logic     hit_found, inv_found, val_found, nsd_found;
  llc_way_t hit_way, inv_way, val_way, nsd_way, idx;
  llc_way_t sel_way;
  logic     sel_evict;

  always_comb begin
    // NOTE: every combinational output is given a default before any
    // conditional code, so no path leaves it unassigned and no latch is inferred.
    hit_found = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    val_found = 1'b0;
    val_way   = evict_ptr;
    nsd_found = 1'b0;
    nsd_way   = evict_ptr;
    idx       = evict_ptr;
    sel_way   = evict_ptr;
    sel_evict = 1'b1;

    // Scans run from the far end down so the last match written is the
    // lowest index (or the nearest way after evict_ptr).
    for (int i = LLC_WAYS - 1; i >= 0; i--) begin
      if (states[i] != INVALID && tags[i] == tag) begin
        hit_found = 1'b1;
        hit_way   = llc_way_t'(i);
      end
      if (states[i] == INVALID) begin
        inv_found = 1'b1;
        inv_way   = llc_way_t'(i);
      end
    end

    for (int k = LLC_WAYS - 1; k >= 0; k--) begin
      idx = way_add(evict_ptr, k);
      if (states[idx] == VALID) begin
        val_found = 1'b1;
        val_way   = idx;
      end
      if (states[idx] != SD) begin
        nsd_found = 1'b1;
        nsd_way   = idx;
      end
    end

    if (hit_found) begin
      sel_way   = hit_way;
      sel_evict = 1'b0;
    end else if (inv_found) begin
      sel_way   = inv_way;
      sel_evict = 1'b0;
    end else if (val_found) begin
      sel_way = val_way;
    end else if (nsd_found) begin
      sel_way = nsd_way;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      way   <= '0;
      evict <= 1'b0;
    end else if (lookup_en) begin
      way   <= sel_way;
      evict <= sel_evict;
    end
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// llc_lookup_ctrl
//   One-at-a-time LLC lookup sequencer: accepts (set, tag), reads the set from
//   the tag/state SRAM, runs lookup_way, and returns way / evict / victim tag
//   and state. Owns the per-set round-robin eviction pointers, advanced on
//   every evicting response handshake.
//   Ports: clk, rst (async, active-low); req_valid/req_ready/req_set/req_tag
//   (request); rd_en/rd_set/rd_tags/rd_states (SRAM, data RD_LAT cycles after
//   rd_en); rsp_valid/rsp_ready/rsp_way/rsp_evict/rsp_evict_tag/
//   rsp_evict_state (response).
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1  // SRAM read latency, 1..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  llc_set_t   req_set,
  input  llc_tag_t   req_tag,
  output logic       rd_en,
  output llc_set_t   rd_set,
  input  llc_tag_t   rd_tags   [LLC_WAYS],
  input  llc_state_t rd_states [LLC_WAYS],
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output llc_way_t   rsp_way,
  output logic       rsp_evict,
  output llc_tag_t   rsp_evict_tag,
  output llc_state_t rsp_evict_state
);

  llc_lookup_state_t state_q, state_d;
  llc_set_t          set_q;
  llc_tag_t          tag_q;
  logic [1:0]        lat_cnt;
  llc_tag_t          tags_buf   [LLC_WAYS];
  llc_state_t        states_buf [LLC_WAYS];
  llc_way_t          evict_ptr  [LLC_SETS];
  logic              lookup_en;
  llc_way_t          lw_way;
  logic              lw_evict;
  logic              capture;
  logic              rsp_fire;

  assign capture  = (state_q == ST_WAIT) && (lat_cnt == 2'd0);
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_READ;
      ST_READ:   state_d = ST_WAIT;
      ST_WAIT:   if (capture) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      lat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        set_q <= req_set;
        tag_q <= req_tag;
      end
      if (state_q == ST_READ) begin
        lat_cnt <= 2'(RD_LAT - 1);
      end else if (state_q == ST_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  // NOTE: these buffers and the pointer array are small flop arrays, and
  // their reset values are architecturally visible (victim tag/state outputs,
  // round-robin start), so they are reset explicitly; a true SRAM would not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < LLC_WAYS; w++) begin
        tags_buf[w]   <= '0;
        states_buf[w] <= INVALID;
      end
    end else if (capture) begin
      for (int w = 0; w < LLC_WAYS; w++) begin
        tags_buf[w]   <= rd_tags[w];
        states_buf[w] <= rd_states[w];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LLC_SETS; s++) begin
        evict_ptr[s] <= '0;
      end
    end else if (rsp_fire && lw_evict) begin
      evict_ptr[set_q] <= way_add(lw_way, 1);
    end
  end

  assign lookup_en = (state_q == ST_LOOKUP);

  lookup_way u_lookup_way (
    .clk       (clk),
    .rst       (rst),
    .lookup_en (lookup_en),
    .tags      (tags_buf),
    .states    (states_buf),
    .tag       (tag_q),
    .evict_ptr (evict_ptr[set_q]),
    .way       (lw_way),
    .evict     (lw_evict)
  );

  assign req_ready       = (state_q == ST_IDLE);
  assign rd_en           = (state_q == ST_READ);
  assign rd_set          = set_q;
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_way         = lw_way;
  assign rsp_evict       = lw_evict;
  assign rsp_evict_tag   = tags_buf[lw_way];
  assign rsp_evict_state = states_buf[lw_way];

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// tb_llc_lookup_ctrl
//   Bench for llc_lookup_ctrl: SRAM model, transaction-level reference model
//   with per-cycle output comparison, directed scenarios and random traffic.
module tb_llc_lookup_ctrl;
  import llc_lookup_ctrl_pkg::*;

  localparam int RD_LAT = 1;
  localparam int RSP_CYC = 3 + RD_LAT;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  llc_set_t   req_set;
  llc_tag_t   req_tag;
  logic       rd_en;
  llc_set_t   rd_set;
  llc_tag_t   rd_tags   [LLC_WAYS];
  llc_state_t rd_states [LLC_WAYS];
  logic       rsp_valid;
  logic       rsp_ready;
  llc_way_t   rsp_way;
  logic       rsp_evict;
  llc_tag_t   rsp_evict_tag;
  llc_state_t rsp_evict_state;

  llc_lookup_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_set         (req_set),
    .req_tag         (req_tag),
    .rd_en           (rd_en),
    .rd_set          (rd_set),
    .rd_tags         (rd_tags),
    .rd_states       (rd_states),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_way         (rsp_way),
    .rsp_evict       (rsp_evict),
    .rsp_evict_tag   (rsp_evict_tag),
    .rsp_evict_state (rsp_evict_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Tag/state array contents, only modified while the controller is idle.
  llc_tag_t   mem_tags   [LLC_SETS][LLC_WAYS];
  llc_state_t mem_states [LLC_SETS][LLC_WAYS];

  // SRAM model: data is correct only in the cycle RD_LAT after rd_en,
  // otherwise it carries junk so a mistimed capture shows up.
  logic     rd_pend = 1'b0;
  llc_set_t rd_addr = '0;
  always @(posedge clk) begin
    rd_pend <= rd_en;
    rd_addr <= rd_set;
  end
  always_comb begin
    for (int w = 0; w < LLC_WAYS; w++) begin
      rd_tags[w]   = rd_pend ? mem_tags[rd_addr][w]   : 16'hBEEF;
      rd_states[w] = rd_pend ? mem_states[rd_addr][w] : VALID;
    end
  end

  // Reference model: which way the rules pick for set s, tag t, pointer p.
  typedef struct packed { llc_way_t way; logic ev; } pick_t;

  function automatic pick_t model_pick(input int s, input llc_tag_t t, input int p);
    pick_t r;
    for (int i = 0; i < LLC_WAYS; i++)
      if (mem_states[s][i] != INVALID && mem_tags[s][i] == t) begin
        r.way = llc_way_t'(i); r.ev = 1'b0; return r;
      end
    for (int i = 0; i < LLC_WAYS; i++)
      if (mem_states[s][i] == INVALID) begin
        r.way = llc_way_t'(i); r.ev = 1'b0; return r;
      end
    for (int k = 0; k < LLC_WAYS; k++)
      if (mem_states[s][(p + k) % LLC_WAYS] == VALID) begin
        r.way = llc_way_t'((p + k) % LLC_WAYS); r.ev = 1'b1; return r;
      end
    for (int k = 0; k < LLC_WAYS; k++)
      if (mem_states[s][(p + k) % LLC_WAYS] != SD) begin
        r.way = llc_way_t'((p + k) % LLC_WAYS); r.ev = 1'b1; return r;
      end
    r.way = llc_way_t'(p); r.ev = 1'b1;
    return r;
  endfunction

  // Transaction timeline: m_cyc = 0 idle, else cycles since acceptance;
  // response is due from cycle RSP_CYC until handshake.
  int    m_cyc = 0;
  int    m_set = 0;
  pick_t m_rsp = '0;
  int    m_ptr [LLC_SETS] = '{default: 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc <= 0;
      for (int s = 0; s < LLC_SETS; s++) m_ptr[s] <= 0;
    end else if (m_cyc == 0) begin
      if (req_valid) begin
        m_cyc <= 1;
        m_set <= int'(req_set);
        m_rsp <= model_pick(int'(req_set), req_tag, m_ptr[req_set]);
      end
    end else if (m_cyc >= RSP_CYC) begin
      if (rsp_ready) begin
        if (m_rsp.ev) m_ptr[m_set] <= (int'(m_rsp.way) + 1) % LLC_WAYS;
        m_cyc <= 0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("req_ready", req_ready, m_cyc == 0);
      check("rd_en", rd_en, m_cyc == 1);
      if (m_cyc == 1) check("rd_set", rd_set, m_set);
      check("rsp_valid", rsp_valid, m_cyc >= RSP_CYC);
      if (m_cyc >= RSP_CYC) begin
        check("rsp_way", rsp_way, m_rsp.way);
        check("rsp_evict", rsp_evict, m_rsp.ev);
        check("rsp_evict_tag", rsp_evict_tag, mem_tags[m_set][m_rsp.way]);
        check("rsp_evict_state", rsp_evict_state, mem_states[m_set][m_rsp.way]);
      end
    end
  end

  task automatic set_row(input int s, input llc_state_t st, input int tag_base);
    for (int w = 0; w < LLC_WAYS; w++) begin
      mem_states[s][w] = st;
      mem_tags[s][w]   = llc_tag_t'(tag_base + w);
    end
  endtask

  // One request/response. Starts and ends on a falling edge. lit_* < 0 skips
  // that literal expectation. During hold cycles a second request is offered.
  task automatic run_req(input string name, input int s, input llc_tag_t t, input int hold,
                         input int lit_way, input int lit_ev, input int lit_tag);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, req_ready, 1);
    req_valid = 1'b1;
    req_set   = llc_set_t'(s);
    req_tag   = t;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, RSP_CYC);
    if (lit_way >= 0) begin
      check({name, "_way"}, rsp_way, lit_way);
      check({name, "_model_way"}, m_rsp.way, lit_way);
    end
    if (lit_ev >= 0) begin
      check({name, "_evict"}, rsp_evict, lit_ev);
      check({name, "_model_evict"}, m_rsp.ev, lit_ev);
    end
    if (lit_tag >= 0) check({name, "_evict_tag"}, rsp_evict_tag, lit_tag);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_set   = llc_set_t'((s + 1) % LLC_SETS);
      @(negedge clk);
      check({name, "_hold_req_ready"}, req_ready, 0);
      check({name, "_hold_rsp_valid"}, rsp_valid, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_ready_after_hs"}, req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_set   = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    for (int s = 0; s < LLC_SETS; s++) set_row(s, INVALID, 0);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rd_en", rd_en, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_way", rsp_way, 0);
    check("reset_rsp_evict", rsp_evict, 0);
    check("reset_evict_tag", rsp_evict_tag, 0);
    check("reset_evict_state", rsp_evict_state, INVALID);
    cmp_en = 1'b1;

    // Hit on way 3
    set_row(5, INVALID, 0);
    mem_states[5][3] = VALID;
    mem_tags[5][3]   = 16'h1A;
    run_req("hit", 5, 16'h1A, 0, 3, 0, -1);

    // Empty way: an INVALID way holding the same tag must not hit
    set_row(5, INVALID, 0);
    mem_states[5][0] = VALID; mem_tags[5][0] = 16'h10;
    mem_states[5][1] = VALID; mem_tags[5][1] = 16'h11;
    mem_tags[5][4]   = 16'h1A;
    run_req("empty", 5, 16'h1A, 0, 2, 0, -1);

    // Round-robin: pointer still 0 after the non-evicting responses
    set_row(5, VALID, 16'h20);
    for (int i = 0; i < LLC_WAYS; i++) run_req("rr", 5, 16'h1A, 0, i, 1, 16'h20 + i);
    run_req("rr_wrap", 5, 16'h1A, 0, 0, 1, 16'h20);
    run_req("rr_wrap1", 5, 16'h1A, 0, 1, 1, 16'h21);

    // All SD except way 6, pointer 2
    set_row(5, SD, 16'h20);
    mem_states[5][6] = VALID;
    run_req("sd_but6", 5, 16'h1A, 0, 6, 1, 16'h26);

    // Move pointer from 7 to 4
    set_row(5, VALID, 16'h20);
    for (int k = 0; k < 5; k++) run_req("rr_adv", 5, 16'h1A, 0, (7 + k) % LLC_WAYS, 1, -1);

    // All SD, pointer 4 -> way 4, then pointer 5
    set_row(5, SD, 16'h20);
    run_req("all_sd", 5, 16'h1A, 0, 4, 1, 16'h24);
    check("all_sd_state_model", mem_states[5][4], SD);
    set_row(5, VALID, 16'h20);
    run_req("after_sd", 5, 16'h1A, 0, 5, 1, 16'h25);

    // Backpressure: hit on set 3 held for 5 cycles with a competing request
    set_row(3, SD, 16'h70);
    mem_states[3][1] = VALID;
    mem_tags[3][1]   = 16'h77;
    run_req("bp", 3, 16'h77, 5, 1, 0, 16'h77);

    // Reset during LOOKUP: set 5 pointer is 6 beforehand
    req_valid = 1'b1;
    req_set   = 4'd5;
    req_tag   = 16'h1A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_rsp_valid_low", rsp_valid, 0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_rsp_valid_after", rsp_valid, 0);
      check("rstmid_req_ready_after", req_ready, 1);
    end
    run_req("rstmid_ptr0", 5, 16'h1A, 0, 0, 1, 16'h20);

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      int s;
      int r;
      s = $urandom_range(0, LLC_SETS - 1);
      for (int w = 0; w < LLC_WAYS; w++) begin
        r = $urandom_range(0, 9);
        mem_states[s][w] = (r < 2) ? INVALID : (r < 6) ? VALID : SD;
        mem_tags[s][w]   = llc_tag_t'($urandom_range(0, 7));
      end
      run_req("rand", s, llc_tag_t'($urandom_range(0, 7)), $urandom_range(0, 2), -1, -1, -1);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
